// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 add/sub datapath.
// Provides field widths, the exponent ceiling, the bias and the packed
// records used between the normalizer stages and its outputs.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int MANT_W  = FRAC_W + 2;
    localparam int LZC_W   = 4;
    localparam int EXP_MAX = 31;
    localparam int BIAS    = 15;

    // Result classification; at most one bit is ever set.
    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } fp16_flags_t;

    // Normalized result as handed to the packer.
    typedef struct packed {
        logic                sign;
        logic [EXP_W-1:0]    exp;
        logic [FRAC_W-1:0]   frac;
        fp16_flags_t         flags;
    } fp16_norm_t;

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero counter for the 11-bit hidden+fraction field.
// Ports:
//   din      - significand bits [10:0] (hidden bit at the top)
//   count    - number of leading zeros, 0..11 (11 when din is all zero)
//   all_zero - din is zero
module leading_zero_counter
    import fp16_pkg::*;
(
    input  logic [FRAC_W:0]   din,
    output logic [LZC_W-1:0]  count,
    output logic              all_zero
);

    // Scan upward so the most significant set bit is the last to update count.
    always_comb begin
        count    = 4'd11;
        all_zero = 1'b1;
        for (int i = 0; i <= FRAC_W; i++) begin
            if (din[i]) begin
                count    = 4'(FRAC_W - i);
                all_zero = 1'b0;
            end else begin
                count    = count;
                all_zero = all_zero;
            end
        end
    end

endmodule

// File: rtl/fp16_normalizer.sv
// Post-add normalization stage of the FP16 adder/subtractor.
// Stage 1 registers the raw sum together with its leading-zero count,
// carry and zero indications; stage 2 registers the normalized
// sign/exponent/fraction and the ovf/unf/zero classification.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   in_valid/in_ready          - input handshake
//   in_sign, in_exp, in_mant   - adder sign, pre-normalization exponent,
//                                12-bit sum (carry, hidden, fraction)
//   out_valid/out_ready        - output handshake
//   out_sign, out_exp, out_frac- normalized result (hidden bit dropped)
//   out_ovf, out_unf, out_zero - overflow to Inf, subnormal, exact zero
module fp16_normalizer
    import fp16_pkg::*;
#(
    parameter int EXP_W  = fp16_pkg::EXP_W,
    parameter int FRAC_W = fp16_pkg::FRAC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W-1:0]    in_exp,
    input  logic [FRAC_W+1:0]   in_mant,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [EXP_W-1:0]    out_exp,
    output logic [FRAC_W-1:0]   out_frac,
    output logic                out_ovf,
    output logic                out_unf,
    output logic                out_zero
);

    localparam logic [EXP_W-1:0] EXP_TOP     = EXP_W'(EXP_MAX);
    localparam logic [EXP_W:0]   EXP_TOP_EXT = (EXP_W+1)'(EXP_MAX);
    localparam logic [EXP_W:0]   EXP_ONE_EXT = (EXP_W+1)'(1);

    // Handshake
    logic s2_adv_s;
    logic s1_adv_s;
    logic in_fire_s;

    // Stage 1 state
    logic                s1_valid_q, s1_valid_d;
    logic                s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]    s1_exp_q,   s1_exp_d;
    logic [FRAC_W:0]     s1_mant_q,  s1_mant_d;
    logic [LZC_W-1:0]    s1_lzc_q,   s1_lzc_d;
    logic                s1_carry_q, s1_carry_d;
    logic                s1_zero_q,  s1_zero_d;

    // Stage 2 state
    logic                s2_valid_q, s2_valid_d;
    fp16_norm_t          s2_q,       s2_d;

    // Combinational helpers
    logic [LZC_W-1:0]    lzc_count_s;
    logic                lzc_zero_s;
    logic [EXP_W:0]      exp_ext_s;
    logic [EXP_W:0]      lzc_ext_s;
    logic [EXP_W:0]      exp_inc_s;
    logic                lzc_fits_s;
    logic [LZC_W-1:0]    shift_amt_s;
    logic [FRAC_W-1:0]   sh1_s, sh2_s, sh4_s, sh8_s;
    fp16_norm_t          norm_s;

    leading_zero_counter u_lzc (
        .din      (in_mant[FRAC_W:0]),
        .count    (lzc_count_s),
        .all_zero (lzc_zero_s)
    );

    // Pipeline advance: a stage may load when it is empty or its contents move on.
    always_comb begin
        s2_adv_s  = !s2_valid_q || out_ready;
        s1_adv_s  = !s1_valid_q || s2_adv_s;
        in_ready  = s1_adv_s && !reset;
        in_fire_s = in_valid && in_ready;
    end

    // Stage 1 next state: capture the raw sum and its leading-zero analysis.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        s1_lzc_d   = s1_lzc_q;
        s1_carry_d = s1_carry_q;
        s1_zero_d  = s1_zero_q;
        if (s1_adv_s) begin
            s1_valid_d = in_fire_s;
            if (in_fire_s) begin
                s1_sign_d  = in_sign;
                s1_exp_d   = in_exp;
                s1_mant_d  = in_mant[FRAC_W:0];
                s1_lzc_d   = lzc_count_s;
                s1_carry_d = in_mant[FRAC_W+1];
                s1_zero_d  = lzc_zero_s && !in_mant[FRAC_W+1];
            end else begin
                s1_sign_d  = s1_sign_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Exponent arithmetic is one bit wider so nothing wraps; pick the left-shift amount.
    always_comb begin
        exp_ext_s  = {1'b0, s1_exp_q};
        lzc_ext_s  = (EXP_W+1)'(s1_lzc_q);
        exp_inc_s  = exp_ext_s + EXP_ONE_EXT;
        lzc_fits_s = lzc_ext_s < exp_ext_s;
        if (lzc_fits_s) begin
            shift_amt_s = s1_lzc_q;
        end else if (exp_ext_s == '0) begin
            shift_amt_s = 4'd0;
        end else begin
            // Subnormals share the scale of exp=1; exp <= 11 here so the cast is lossless.
            shift_amt_s = LZC_W'(exp_ext_s - EXP_ONE_EXT);
        end
    end

    // Left shifter: 1/2/4/8 mux cascade with zero fill; bits above the fraction fall off.
    always_comb begin
        sh1_s = shift_amt_s[0] ? {s1_mant_q[FRAC_W-2:0], 1'b0}  : s1_mant_q[FRAC_W-1:0];
        sh2_s = shift_amt_s[1] ? {sh1_s[FRAC_W-3:0], 2'b00}     : sh1_s;
        sh4_s = shift_amt_s[2] ? {sh2_s[FRAC_W-5:0], 4'b0000}   : sh2_s;
        sh8_s = shift_amt_s[3] ? {sh4_s[FRAC_W-9:0], 8'h00}     : sh4_s;
    end

    // Normalization result in priority order: special, zero, carry, normal, subnormal.
    always_comb begin
        norm_s      = '0;
        norm_s.sign = s1_sign_q;
        if (s1_exp_q == EXP_TOP) begin
            norm_s.exp  = EXP_TOP;
            norm_s.frac = s1_mant_q[FRAC_W-1:0];
        end else if (s1_zero_q) begin
            norm_s.sign       = 1'b0;
            norm_s.flags.zero = 1'b1;
        end else if (s1_carry_q) begin
            if (exp_inc_s == EXP_TOP_EXT) begin
                norm_s.exp       = EXP_TOP;
                norm_s.flags.ovf = 1'b1;
            end else begin
                norm_s.exp  = exp_inc_s[EXP_W-1:0];
                // Carry out: drop one LSB, no rounding at this stage.
                norm_s.frac = s1_mant_q[FRAC_W:1];
            end
        end else if (lzc_fits_s) begin
            norm_s.exp  = EXP_W'(exp_ext_s - lzc_ext_s);
            norm_s.frac = sh8_s;
        end else begin
            norm_s.exp       = '0;
            norm_s.frac      = sh8_s;
            norm_s.flags.unf = 1'b1;
        end
    end

    // Stage 2 next state: load a fresh result only when stage 1 holds a beat.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = norm_s;
            end else begin
                s2_d = s2_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_lzc_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_mant_q  <= s1_mant_d;
            s1_lzc_q   <= s1_lzc_d;
            s1_carry_q <= s1_carry_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    // Outputs come straight from the stage 2 registers.
    always_comb begin
        out_valid = s2_valid_q;
        out_sign  = s2_q.sign;
        out_exp   = s2_q.exp;
        out_frac  = s2_q.frac;
        out_ovf   = s2_q.flags.ovf;
        out_unf   = s2_q.flags.unf;
        out_zero  = s2_q.flags.zero;
    end

endmodule

// File: doc/fp16_normalizer.md
Name: fp16_normalizer

Overview:
- Post-add normalization stage of the half-precision adder/subtractor. This is the left-shift counterpart of the alignment right shifter.
- Takes the raw 12-bit significand sum (carry, hidden and fraction bits), the pre-normalization exponent and the sign.
- Produces a normalized FP16 exponent/fraction with overflow, underflow and zero flags.
- Two-stage pipeline with valid/ready handshake on both sides. Sits between the significand adder and the result packer.

Parameters:
- EXP_W, 5, exponent field width
- FRAC_W, 10, stored fraction width; input significand is FRAC_W+2 bits

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input this cycle
- in_sign  in  1  result sign from adder
- in_exp  in  EXP_W  pre-normalization exponent (larger operand's exponent)
- in_mant  in  FRAC_W+2  bit 11 carry, bit 10 hidden, bits 9:0 fraction
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_sign  out  1  normalized sign
- out_exp  out  EXP_W  normalized exponent field
- out_frac  out  FRAC_W  normalized fraction (hidden bit dropped)
- out_ovf  out  1  result overflowed to infinity
- out_unf  out  1  result is subnormal
- out_zero  out  1  result is exactly zero

Behaviour:
- Reset: while reset is high, valids clear, all output data/flags go to 0, and in_ready is 0. in_ready may rise the cycle after reset deasserts. Reset mid-operation discards in-flight beats; none is emitted.
- Latency is 2 cycles from input accept to out_valid. Throughput is 1 beat per cycle when out_ready stays high.
- Handshake:
  - Transfer occurs on valid && ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !reset.
  - out_* are held stable while out_valid && !out_ready. Order is preserved and no beat is dropped or duplicated.
- Stage 1 (registered):
  - Captures the inputs.
  - Computes lzc = leading zeros of in_mant[10:0], range 0..11 (11 means zero).
  - Computes the carry and zero flags.
- Stage 2 (registered), case priority:
  1. in_exp == 31 (Inf/NaN): pass through. exp=31, frac=in_mant[9:0], flags 0.
  2. in_mant == 0: exp=0, frac=0, sign forced to 0 (+0), zero=1.
  3. Carry (in_mant[11]=1): right shift 1, LSB truncated (no rounding), exp = in_exp+1. If exp+1 == 31: exp=31, frac=0, ovf=1.
  4. lzc < in_exp: left shift by lzc, exp = in_exp - lzc.
  5. lzc >= in_exp: left shift by max(in_exp-1, 0), exp=0, unf=1. Subnormal scale matches exp=1.
- Shift amounts are 0..10, with zero fill. Exponent arithmetic uses EXP_W+1 bits internally; no wrap-around.
- Flags are mutually exclusive.

Decomposition:
- Package fp16_pkg:
  - EXP_W, FRAC_W, EXP_MAX (31), BIAS (15).
  - Packed struct fp16_flags_t {ovf, unf, zero}.
  - Packed struct fp16_norm_t {sign, exp, frac, flags}; stage 2 registers and outputs use this.
- Sub-module leading_zero_counter: combinational 11-bit LZC, 4-bit count, all-zero output. Instantiated once in stage 1.
- The left shifter is a 4-stage mux cascade (1/2/4/8) inside this block.

Test Plan:
- Already normalized: mant=0x400, exp=15, sign=0, out_ready=1 -> 2 cycles later out_exp=15, out_frac=0x000, flags 0.
- Carry: mant=0x801, exp=15 -> exp=16, frac=0x000 (LSB truncated). mant=0xC01, exp=30 -> exp=31, frac=0, ovf=1.
- Cancellation/LZC:
  - mant=0x001, exp=20 -> exp=10, frac=0x000.
  - mant=0x001, exp=5 -> shift 4, exp=0, frac=0x010, unf=1.
  - mant=0x0F0, exp=0 -> exp=0, frac=0x0F0, unf=1.
- Zero and special: mant=0x000, exp=12, sign=1 -> sign=0, exp=0, frac=0, zero=1. exp=31, mant=0x6AB -> exp=31, frac=0x2AB, flags 0.
- Backpressure: 4 back-to-back beats, out_ready=0 for cycles 2-5 -> in_ready drops after 2 beats held; out data is stable while stalled; all 4 emerge in order once out_ready=1.
- Reset mid-stream: 2 beats in flight, assert reset 1 cycle -> out_valid=0 and in_ready=0 during reset; no stale beat appears afterward; the next input emerges 2 cycles after accept.
